// File: rtl/llc_op_sched.sv
// llc_op_sched: arbitrates a CPU request FIFO and a one-deep snoop holding register onto a
// single LLC request port, with snoop priority, CPU starvation relief and op statistics.
module llc_op_sched #(
    parameter int unsigned CPU_DEPTH  = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [3:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              snp_valid,
    output logic              snp_ready,
    input  logic [3:0]        snp_op,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              llc_valid,
    output logic [3:0]        llc_op,
    output logic [ADDR_W-1:0] llc_addr,
    input  logic              llc_hold,
    input  logic              llc_hit,
    input  logic              llc_miss,
    output logic              bad_op,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int unsigned PTR_W = $clog2(CPU_DEPTH);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    state_e              state_q;
    logic                llc_valid_q;
    logic [3:0]          llc_op_q;
    logic [ADDR_W-1:0]   llc_addr_q;
    logic                sel_cpu_q;
    logic                bad_op_q;
    logic [STV_W-1:0]    starve_q;

    logic [PTR_W:0]      wptr_q;
    logic [PTR_W:0]      rptr_q;
    logic [3:0]          fifo_op_q   [CPU_DEPTH];
    logic [ADDR_W-1:0]   fifo_addr_q [CPU_DEPTH];

    logic                snp_full_q;
    logic [3:0]          snp_op_q;
    logic [ADDR_W-1:0]   snp_addr_q;

    logic [31:0]         rd_cnt_q;
    logic [31:0]         wr_cnt_q;
    logic [31:0]         hit_cnt_q;
    logic [31:0]         miss_cnt_q;

    logic fifo_empty, fifo_full;
    logic cpu_legal, snp_legal, cpu_acc, snp_acc, cpu_push, snp_push;
    logic cpu_pend, grant_cpu, grant_snp, op_done, cpu_pop;
    logic [3:0]        head_op;
    logic [ADDR_W-1:0] head_addr;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                        (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign cpu_ready  = !fifo_full;
    assign snp_ready  = !snp_full_q;
    assign head_op    = fifo_op_q[rptr_q[PTR_W-1:0]];
    assign head_addr  = fifo_addr_q[rptr_q[PTR_W-1:0]];

    // Handshake decode, arbitration and completion detection
    always_comb begin
        cpu_legal = cpu_op inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
        snp_legal = snp_op inside {4'd3, 4'd4, 4'd5, 4'd6};
        cpu_acc   = cpu_valid && cpu_ready;
        snp_acc   = snp_valid && snp_ready;
        cpu_push  = cpu_acc && cpu_legal;
        snp_push  = snp_acc && snp_legal;
        cpu_pend  = !fifo_empty;
        grant_cpu = (state_q == StIdle) && cpu_pend &&
                    (!snp_full_q || (starve_q == STARVE_LIM));
        grant_snp = (state_q == StIdle) && snp_full_q && !grant_cpu;
        op_done   = ((state_q == StIssue) && !llc_hold) || (state_q == StHold);
        // CPU entries stay queued until their op completes at the LLC
        cpu_pop   = op_done && sel_cpu_q;
    end

    // CPU FIFO storage; written only on a legal accepted op
    always_ff @(posedge clk) begin
        if (cpu_push) begin
            fifo_op_q[wptr_q[PTR_W-1:0]]   <= cpu_op;
            fifo_addr_q[wptr_q[PTR_W-1:0]] <= cpu_addr;
        end
    end

    // FIFO pointers, snoop holding register, starvation counter and bad-op pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            snp_full_q <= 1'b0;
            snp_op_q   <= '0;
            snp_addr_q <= '0;
            starve_q   <= '0;
            bad_op_q   <= 1'b0;
        end else begin
            bad_op_q <= (cpu_acc && !cpu_legal) || (snp_acc && !snp_legal);
            if (cpu_push) wptr_q <= wptr_q + 1'b1;
            if (cpu_pop)  rptr_q <= rptr_q + 1'b1;
            // The snoop op moves into the LLC output registers at grant, freeing the holding
            // register so a continuous snoop stream stays pending at every arbitration point.
            if (snp_push) begin
                snp_full_q <= 1'b1;
                snp_op_q   <= snp_op;
                snp_addr_q <= snp_addr;
            end else if (grant_snp) begin
                snp_full_q <= 1'b0;
            end
            if (grant_cpu) begin
                starve_q <= '0;
            end else if (grant_snp && cpu_pend) begin
                if (starve_q != STARVE_LIM) starve_q <= starve_q + 1'b1;
            end else if (!cpu_pend) begin
                starve_q <= '0;
            end
        end
    end

    // Issue FSM with registered LLC request outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            llc_valid_q <= 1'b0;
            llc_op_q    <= '0;
            llc_addr_q  <= '0;
            sel_cpu_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_cpu) begin
                        llc_op_q    <= head_op;
                        llc_addr_q  <= head_addr;
                        sel_cpu_q   <= 1'b1;
                        llc_valid_q <= 1'b1;
                        state_q     <= StIssue;
                    end else if (grant_snp) begin
                        llc_op_q    <= snp_op_q;
                        llc_addr_q  <= snp_addr_q;
                        sel_cpu_q   <= 1'b0;
                        llc_valid_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (llc_hold) begin
                        state_q <= StHold;
                    end else begin
                        llc_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                StHold: begin
                    llc_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    llc_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    // Statistics, updated on the completion cycle of each op
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (op_done) begin
            if (llc_op_q == 4'd8) begin
                rd_cnt_q   <= '0;
                wr_cnt_q   <= '0;
                hit_cnt_q  <= '0;
                miss_cnt_q <= '0;
            end else if (llc_op_q <= 4'd2) begin
                if (llc_op_q == 4'd1) wr_cnt_q <= sat_inc(wr_cnt_q);
                else                  rd_cnt_q <= sat_inc(rd_cnt_q);
                // Hit takes precedence when the LLC flags both
                if (llc_hit)       hit_cnt_q  <= sat_inc(hit_cnt_q);
                else if (llc_miss) miss_cnt_q <= sat_inc(miss_cnt_q);
            end
        end
    end

    assign llc_valid = llc_valid_q;
    assign llc_op    = llc_op_q;
    assign llc_addr  = llc_addr_q;
    assign bad_op    = bad_op_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_llc_op_sched.sv
// tb_llc_op_sched: directed, self-checking bench for llc_op_sched.
module tb_llc_op_sched;

    logic        clk;
    logic        rst;
    logic        cpu_valid, cpu_ready;
    logic [3:0]  cpu_op;
    logic [31:0] cpu_addr;
    logic        snp_valid, snp_ready;
    logic [3:0]  snp_op;
    logic [31:0] snp_addr;
    logic        llc_valid;
    logic [3:0]  llc_op;
    logic [31:0] llc_addr;
    logic        llc_hold, llc_hit, llc_miss;
    logic        bad_op;
    logic [31:0] rd_cnt, wr_cnt, hit_cnt, miss_cnt;

    int n_chk = 0;
    int n_bad = 0;

    logic [3:0]  mon_op   [$];
    logic [31:0] mon_addr [$];
    logic        prev_valid = 1'b0;

    logic [3:0]  sv_exp   [15];
    logic [3:0]  fl_op    [6];
    logic [31:0] fl_addr  [6];

    llc_op_sched #(
        .CPU_DEPTH  (4),
        .ADDR_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .cpu_op    (cpu_op),
        .cpu_addr  (cpu_addr),
        .snp_valid (snp_valid),
        .snp_ready (snp_ready),
        .snp_op    (snp_op),
        .snp_addr  (snp_addr),
        .llc_valid (llc_valid),
        .llc_op    (llc_op),
        .llc_addr  (llc_addr),
        .llc_hold  (llc_hold),
        .llc_hit   (llc_hit),
        .llc_miss  (llc_miss),
        .bad_op    (bad_op),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every new LLC issue (rising llc_valid) in order
    always @(negedge clk) begin
        if (llc_valid && !prev_valid) begin
            mon_op.push_back(llc_op);
            mon_addr.push_back(llc_addr);
        end
        prev_valid <= llc_valid;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_push(input logic [3:0] op, input logic [31:0] addr);
        int waited = 0;
        @(negedge clk);
        while (!cpu_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited == 100) check("cpu_push_timeout", {63'd0, cpu_ready}, 64'd1);
        cpu_valid = 1'b1;
        cpu_op    = op;
        cpu_addr  = addr;
        @(posedge clk);
        #1 cpu_valid = 1'b0;
    endtask

    task automatic snp_push(input logic [3:0] op, input logic [31:0] addr);
        int waited = 0;
        @(negedge clk);
        while (!snp_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited == 100) check("snp_push_timeout", {63'd0, snp_ready}, 64'd1);
        snp_valid = 1'b1;
        snp_op    = op;
        snp_addr  = addr;
        @(posedge clk);
        #1 snp_valid = 1'b0;
    endtask

    initial begin
        int base;
        logic [31:0] ea;
        sv_exp  = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd3, 4'd3, 4'd3, 4'd3, 4'd1,
                    4'd3, 4'd3, 4'd3, 4'd3, 4'd2};
        fl_op   = '{4'd6, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
        fl_addr = '{32'h6000, 32'h200, 32'h204, 32'h208, 32'h20C, 32'h210};

        rst = 1'b1; cpu_valid = 1'b0; cpu_op = '0; cpu_addr = '0;
        snp_valid = 1'b0; snp_op = '0; snp_addr = '0;
        llc_hold = 1'b0; llc_hit = 1'b0; llc_miss = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_llc_valid", {63'd0, llc_valid}, 64'd0);
        check("rst_llc_op", {60'd0, llc_op}, 64'd0);
        check("rst_llc_addr", {32'd0, llc_addr}, 64'd0);
        check("rst_bad_op", {63'd0, bad_op}, 64'd0);
        check("rst_cpu_ready", {63'd0, cpu_ready}, 64'd1);
        check("rst_snp_ready", {63'd0, snp_ready}, 64'd1);
        check("rst_rd_cnt", {32'd0, rd_cnt}, 64'd0);
        rst = 1'b0;

        // Single read hit: valid appears two edges after accept, for one cycle
        llc_hit = 1'b1;
        cpu_push(4'd0, 32'h1000);
        @(negedge clk);
        check("rd_lat_n1", {63'd0, llc_valid}, 64'd0);
        @(negedge clk);
        check("rd_valid", {63'd0, llc_valid}, 64'd1);
        check("rd_op", {60'd0, llc_op}, 64'd0);
        check("rd_addr", {32'd0, llc_addr}, 64'h1000);
        @(negedge clk);
        check("rd_valid_drop", {63'd0, llc_valid}, 64'd0);
        check("rd_cnt1", {32'd0, rd_cnt}, 64'd1);
        check("hit_cnt1", {32'd0, hit_cnt}, 64'd1);
        check("miss_cnt0", {32'd0, miss_cnt}, 64'd0);

        // Write with hold: valid for two cycles, op/addr stable, counted once
        llc_hold = 1'b1;
        cpu_push(4'd1, 32'h2000);
        @(negedge clk);
        @(negedge clk);
        check("wr_issue_valid", {63'd0, llc_valid}, 64'd1);
        check("wr_issue_addr", {32'd0, llc_addr}, 64'h2000);
        @(negedge clk);
        check("wr_hold_valid", {63'd0, llc_valid}, 64'd1);
        check("wr_hold_op", {60'd0, llc_op}, 64'd1);
        check("wr_hold_addr", {32'd0, llc_addr}, 64'h2000);
        check("wr_hold_cnt", {32'd0, wr_cnt}, 64'd0);
        @(negedge clk);
        check("wr_done_valid", {63'd0, llc_valid}, 64'd0);
        check("wr_cnt1", {32'd0, wr_cnt}, 64'd1);
        @(negedge clk);
        check("wr_cnt_once", {32'd0, wr_cnt}, 64'd1);
        check("hit_cnt2", {32'd0, hit_cnt}, 64'd2);
        llc_hold = 1'b0;

        // Clear op in the middle of a sequence
        cpu_push(4'd0, 32'h10); cycles(3);
        cpu_push(4'd1, 32'h14); cycles(3);
        check("pre_clr_rd", {32'd0, rd_cnt}, 64'd2);
        cpu_push(4'd8, 32'h0); cycles(3);
        check("clr_rd", {32'd0, rd_cnt}, 64'd0);
        check("clr_wr", {32'd0, wr_cnt}, 64'd0);
        check("clr_hit", {32'd0, hit_cnt}, 64'd0);
        check("clr_miss", {32'd0, miss_cnt}, 64'd0);
        llc_hit = 1'b0; llc_miss = 1'b1;
        cpu_push(4'd2, 32'h18); cycles(3);
        check("post_clr_rd", {32'd0, rd_cnt}, 64'd1);
        check("post_clr_miss", {32'd0, miss_cnt}, 64'd1);
        check("post_clr_wr", {32'd0, wr_cnt}, 64'd0);
        check("post_clr_hit", {32'd0, hit_cnt}, 64'd0);

        // Hit and miss together count as a hit only
        llc_hit = 1'b1; llc_miss = 1'b1;
        cpu_push(4'd0, 32'h1C); cycles(3);
        check("both_hit", {32'd0, hit_cnt}, 64'd1);
        check("both_miss", {32'd0, miss_cnt}, 64'd1);
        check("both_rd", {32'd0, rd_cnt}, 64'd2);

        // Print and snoop ops leave counters alone
        cpu_push(4'd9, 32'h20); cycles(3);
        snp_push(4'd4, 32'h40); cycles(3);
        check("nochg_rd", {32'd0, rd_cnt}, 64'd2);
        check("nochg_wr", {32'd0, wr_cnt}, 64'd0);
        check("nochg_hit", {32'd0, hit_cnt}, 64'd1);
        check("nochg_miss", {32'd0, miss_cnt}, 64'd1);

        // Illegal ops on both sides in one cycle: single pulse, nothing issued
        base = mon_op.size();
        @(negedge clk);
        cpu_valid = 1'b1; cpu_op = 4'd7; cpu_addr = 32'hBAD0;
        snp_valid = 1'b1; snp_op = 4'd2; snp_addr = 32'hBAD4;
        @(posedge clk);
        #1 cpu_valid = 1'b0; snp_valid = 1'b0;
        @(negedge clk);
        check("bad_pulse", {63'd0, bad_op}, 64'd1);
        @(negedge clk);
        check("bad_single", {63'd0, bad_op}, 64'd0);
        cycles(3);
        check("bad_no_issue", 64'(mon_op.size()), 64'(base));
        check("bad_no_valid", {63'd0, llc_valid}, 64'd0);
        @(negedge clk);
        cpu_valid = 1'b1; cpu_op = 4'hA;
        @(posedge clk);
        #1 cpu_valid = 1'b0;
        @(negedge clk);
        check("bad_cpu_only", {63'd0, bad_op}, 64'd1);
        cycles(2);

        // Continuous snoops with three CPU ops: CPU forced after every four snoop grants
        llc_hit = 1'b0; llc_miss = 1'b0;
        base = mon_op.size();
        @(negedge clk);
        snp_valid = 1'b1; snp_op = 4'd3; snp_addr = 32'h5000;
        cpu_valid = 1'b1; cpu_op = 4'd0; cpu_addr = 32'h100;
        @(posedge clk);
        #1 cpu_valid = 1'b0;
        cpu_push(4'd1, 32'h104);
        cpu_push(4'd2, 32'h108);
        cycles(40);
        snp_valid = 1'b0;
        cycles(6);
        check("starve_count", {63'd0, mon_op.size() >= base + 15}, 64'd1);
        for (int i = 0; i < 15; i++) begin
            if (mon_op.size() > base + i) begin
                ea = (sv_exp[i] == 4'd3) ? 32'h5000 : 32'h100 + 32'(sv_exp[i]) * 32'd4;
                check($sformatf("starve_op%0d", i), {60'd0, mon_op[base + i]},
                      {60'd0, sv_exp[i]});
                check($sformatf("starve_addr%0d", i), {32'd0, mon_addr[base + i]}, {32'd0, ea});
            end
        end
        check("starve_rd", {32'd0, rd_cnt}, 64'd4);
        check("starve_wr", {32'd0, wr_cnt}, 64'd1);

        // FIFO fill with LLC holding every op
        llc_hold = 1'b1; llc_miss = 1'b1;
        base = mon_op.size();
        @(negedge clk);
        snp_valid = 1'b1; snp_op = 4'd6; snp_addr = 32'h6000;
        cpu_valid = 1'b1; cpu_op = 4'd0; cpu_addr = 32'h200;
        @(posedge clk);
        #1 snp_valid = 1'b0; cpu_valid = 1'b0;
        cpu_push(4'd1, 32'h204);
        cpu_push(4'd2, 32'h208);
        cpu_push(4'd0, 32'h20C);
        @(negedge clk);
        check("full_not_ready", {63'd0, cpu_ready}, 64'd0);
        cpu_push(4'd1, 32'h210);
        cycles(30);
        check("full_ready_back", {63'd0, cpu_ready}, 64'd1);
        check("full_issue_cnt", 64'(mon_op.size()), 64'(base + 6));
        for (int i = 0; i < 6; i++) begin
            if (mon_op.size() > base + i) begin
                check($sformatf("full_op%0d", i), {60'd0, mon_op[base + i]}, {60'd0, fl_op[i]});
                check($sformatf("full_addr%0d", i), {32'd0, mon_addr[base + i]},
                      {32'd0, fl_addr[i]});
            end
        end
        check("full_rd", {32'd0, rd_cnt}, 64'd7);
        check("full_wr", {32'd0, wr_cnt}, 64'd3);
        check("full_miss", {32'd0, miss_cnt}, 64'd6);
        check("full_hit", {32'd0, hit_cnt}, 64'd1);

        // Reset while an op is in HOLD abandons it
        llc_hit = 1'b1; llc_miss = 1'b0;
        cpu_push(4'd1, 32'h300);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("hold_before_rst", {63'd0, llc_valid}, 64'd1);
        check("wr_before_rst", {32'd0, wr_cnt}, 64'd3);
        rst = 1'b1;
        @(negedge clk);
        check("rst_hold_valid", {63'd0, llc_valid}, 64'd0);
        check("rst_hold_wr", {32'd0, wr_cnt}, 64'd0);
        check("rst_hold_rd", {32'd0, rd_cnt}, 64'd0);
        check("rst_hold_hit", {32'd0, hit_cnt}, 64'd0);
        check("rst_hold_miss", {32'd0, miss_cnt}, 64'd0);
        rst = 1'b0;
        llc_hold = 1'b0;
        base = mon_op.size();
        cycles(5);
        check("rst_no_reissue", 64'(mon_op.size()), 64'(base));
        check("rst_after_wr", {32'd0, wr_cnt}, 64'd0);
        check("rst_after_ready", {63'd0, cpu_ready}, 64'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
